// File: rtl/linebuf_win3x3_stream.sv
// Streaming 3x3 window generator: two line buffers feed a shifting 3x3 window,
// emitted through one output register with valid/ready backpressure.
module linebuf_win3x3_stream #(
  parameter int DATA_W = 24,
  parameter int IMG_W  = 480,
  parameter int IMG_H  = 272,
  parameter int COL_W  = 12,
  parameter int ROW_W  = 12
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iStart,
  input  logic                  iValid,
  input  logic [DATA_W-1:0]     iData,
  output logic                  oReady,
  output logic [9*DATA_W-1:0]   oWin,
  output logic                  oValid,
  input  logic                  iReady,
  output logic                  oDone,
  output logic                  oBusy
);

  localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [COL_W-1:0]     r_col;
  logic [ROW_W-1:0]     r_row;
  logic [DATA_W-1:0]    r_lb0 [IMG_W];
  logic [DATA_W-1:0]    r_lb1 [IMG_W];
  logic [9*DATA_W-1:0]  r_win;
  logic [9*DATA_W-1:0]  w_win_next;
  logic [9*DATA_W-1:0]  r_owin;
  logic                 r_ovalid;
  logic                 r_done;
  logic                 w_ready;
  logic                 w_busy;
  logic                 w_accept;
  logic                 w_xfer;
  logic                 w_last_pix;
  logic                 w_load;
  logic [AW-1:0]        w_addr;
  logic [DATA_W-1:0]    w_top;
  logic [DATA_W-1:0]    w_mid;

  assign w_accept   = iValid & w_ready;
  assign w_xfer     = r_ovalid & iReady;
  assign w_last_pix = (r_row == LAST_ROW) && (r_col == LAST_COL);
  // The c>=2 gate keeps windows from straddling a line boundary; r>=2 hides stale lines.
  assign w_load     = w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
  assign w_addr     = r_col[AW-1:0];
  assign w_top      = r_lb1[w_addr];
  assign w_mid      = r_lb0[w_addr];

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (iStart) w_state_next = S_RUN;
      S_RUN:   if (w_accept && w_last_pix) w_state_next = S_DRAIN;
      S_DRAIN: if (w_xfer) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy  = (r_state != S_IDLE);
    w_ready = (r_state == S_RUN) && (!r_ovalid || iReady);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_state == S_IDLE && iStart) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Line storage is deliberately left unreset.
  always_ff @(posedge iClk) begin
    if (w_accept) begin
      r_lb1[w_addr] <= r_lb0[w_addr];
      r_lb0[w_addr] <= iData;
    end
  end

  always_comb begin
    w_win_next = r_win;
    for (int i = 0; i < 3; i++) begin
      w_win_next[(i*3)*DATA_W   +: DATA_W] = r_win[(i*3+1)*DATA_W +: DATA_W];
      w_win_next[(i*3+1)*DATA_W +: DATA_W] = r_win[(i*3+2)*DATA_W +: DATA_W];
    end
    w_win_next[2*DATA_W +: DATA_W] = w_top;
    w_win_next[5*DATA_W +: DATA_W] = w_mid;
    w_win_next[8*DATA_W +: DATA_W] = iData;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      r_win    <= '0;
      r_owin   <= '0;
      r_ovalid <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      if (w_accept) r_win <= w_win_next;
      if (w_load) begin
        r_owin   <= w_win_next;
        r_ovalid <= 1'b1;
      end else if (w_xfer) begin
        r_ovalid <= 1'b0;
      end
      r_done <= (r_state == S_DRAIN) && w_xfer;
    end
  end

  assign oReady = w_ready;
  assign oBusy  = w_busy;
  assign oWin   = r_owin;
  assign oValid = r_ovalid;
  assign oDone  = r_done;

endmodule
